// File: rtl/double_dabble_bin2bcd_seq.sv
// double_dabble_bin2bcd_seq: bit-serial double-dabble binary-to-BCD converter with valid/ready handshakes; DOUBLE_DABBLE_SIGNED_EN adds two's-complement input
function automatic int get_num_digits(input longint unsigned v);
  longint unsigned x;
  int n;
  x = v;
  n = 1;
  while (x >= 64'd10) begin
    x = x / 64'd10;
    n++;
  end
  return n;
endfunction

module double_dabble_bin2bcd_seq #(
  parameter int WIDTH = 16,
  parameter int NUM_DIGITS = get_num_digits((64'd1 << WIDTH) - 64'd1),
  parameter bit CHECK_PARAM = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        bin,
  input  logic                    signed_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    neg,
  output logic                    busy
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
  state_t state, state_d;
  logic [BW-1:0] bcd_q, adj;
  logic [WIDTH-1:0] mag_q, mag_in;
  logic [CW-1:0] cnt;
  logic last, accept;
  if (CHECK_PARAM) begin : g_check
    if (WIDTH < 1) $fatal(1, "WIDTH must be at least 1");
    if (NUM_DIGITS < get_num_digits((64'd1 << WIDTH) - 64'd1)) $fatal(1, "NUM_DIGITS too small for WIDTH");
  end
  assign last = cnt == CW'(WIDTH - 1);
  assign accept = state == IDLE && in_valid;
  assign in_ready = state == IDLE;
  assign out_valid = state == HOLD;
  assign busy = state != IDLE;
  assign bcd = bcd_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state == IDLE ? (in_valid ? CONV : IDLE) :
              state == CONV ? (last ? HOLD : CONV) :
              (out_ready ? IDLE : HOLD);
  end
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bcd_q <= '0;
      mag_q <= '0;
      cnt <= '0;
    end else if (accept) begin
      bcd_q <= '0;
      mag_q <= mag_in;
      cnt <= '0;
    end else if (state == CONV) begin
      {bcd_q, mag_q} <= {adj[BW-2:0], mag_q, 1'b0};
      cnt <= cnt + 1'b1;
    end
`ifdef DOUBLE_DABBLE_SIGNED_EN
  logic neg_in, neg_q;
  assign neg_in = signed_mode & bin[WIDTH-1];
  assign mag_in = neg_in ? -bin : bin;
  assign neg = neg_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) neg_q <= 1'b0;
    else if (accept) neg_q <= neg_in;
`else
  logic unused;
  assign unused = signed_mode;
  assign mag_in = bin;
  assign neg = 1'b0;
`endif
endmodule

// File: tb/tb_double_dabble_bin2bcd_seq.sv
// tb_double_dabble_bin2bcd_seq: randomized self-checking bench against a decimal-arithmetic reference model
module tb_double_dabble_bin2bcd_seq;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic iv16 = 0, iv1 = 0, iv32 = 0, out_ready = 0, signed_mode = 0;
  logic [15:0] bin16 = '0;
  logic [0:0] bin1 = '0;
  logic [31:0] bin32 = '0;
  logic ir16, ov16, neg16, busy16, ir1, ov1, neg1, busy1, ir32, ov32, neg32, busy32;
  logic [19:0] bcd16;
  logic [3:0] bcd1;
  logic [39:0] bcd32;
  int n_checks = 0, n_fail = 0;

  double_dabble_bin2bcd_seq u16 (.clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .bin(bin16),
    .signed_mode(signed_mode), .out_valid(ov16), .out_ready(out_ready), .bcd(bcd16), .neg(neg16), .busy(busy16));
  double_dabble_bin2bcd_seq #(.WIDTH(1), .NUM_DIGITS(1)) u1 (.clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .bin(bin1), .signed_mode(signed_mode), .out_valid(ov1), .out_ready(out_ready), .bcd(bcd1), .neg(neg1), .busy(busy1));
  double_dabble_bin2bcd_seq #(.WIDTH(32), .NUM_DIGITS(10)) u32 (.clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .bin(bin32), .signed_mode(signed_mode), .out_valid(ov32), .out_ready(out_ready), .bcd(bcd32), .neg(neg32), .busy(busy32));

  // Reference: take the w-bit value, negate if signed and negative, then peel decimal digits.
  function automatic void model(input int w, input logic [31:0] v, input logic sm, output logic [39:0] d, output logic n);
    longint unsigned m;
    m = {32'd0, v} & ((64'd1 << w) - 64'd1);
    n = 1'b0;
`ifdef DOUBLE_DABBLE_SIGNED_EN
    if (sm && ((m >> (w - 1)) & 64'd1) != 0) begin
      m = (64'd1 << w) - m;
      n = 1'b1;
    end
`endif
    d = '0;
    for (int i = 0; i < 10; i++) begin
      d[4*i+:4] = 4'(m % 64'd10);
      m = m / 64'd10;
    end
  endfunction

  task automatic conv16(input logic [15:0] v, input logic sm, output logic [19:0] d, output logic n, output int lat);
    int k = 0;
    while (!ir16 && k < 100) begin @(posedge clk); #1; k++; end
    bin16 = v; signed_mode = sm; iv16 = 1; out_ready = 0;
    @(posedge clk); #1;
    iv16 = 0;
    lat = 0;
    while (!ov16 && lat < 100) begin @(posedge clk); #1; lat++; end
    d = bcd16; n = neg16;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1; iv16 = 1; bin16 = 16'd77;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", ir16); end
    n_checks++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", ov16); end
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy16); end
    n_checks++; if (bcd16 !== 20'h0) begin n_fail++; $display("FAIL reset bcd: got %h want 00000", bcd16); end
    n_checks++; if (neg16 !== 1'b0) begin n_fail++; $display("FAIL reset neg: got %b want 0", neg16); end
    @(negedge clk);
    rst = 0; iv16 = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_max;
    logic [19:0] d; logic n; int lat; logic [39:0] e; logic en;
    conv16(16'hFFFF, 1'b0, d, n, lat);
    model(16, 32'hFFFF, 1'b0, e, en);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL max latency: got %0d want 16", lat); end
    n_checks++; if (d !== e[19:0]) begin n_fail++; $display("FAIL max bcd: got %h want %h", d, e[19:0]); end
    n_checks++; if (n !== 1'b0) begin n_fail++; $display("FAIL max neg: got %b want 0", n); end
  endtask

  task automatic test_backpressure;
    logic [39:0] e; logic en; int k = 0;
    model(16, 32'd12345, 1'b0, e, en);
    bin16 = 16'd12345; signed_mode = 0; iv16 = 1; out_ready = 0;
    @(posedge clk); #1;
    bin16 = 16'd999;
    while (!ov16 && k < 100) begin @(posedge clk); #1; k++; end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (bcd16 !== e[19:0]) begin n_fail++; $display("FAIL bp bcd cyc %0d: got %h want %h", i, bcd16, e[19:0]); end
      n_checks++; if (ir16 !== 1'b0 || busy16 !== 1'b1 || ov16 !== 1'b1) begin
        n_fail++; $display("FAIL bp flags cyc %0d: got ready=%b busy=%b valid=%b want 0 1 1", i, ir16, busy16, ov16); end
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    n_checks++; if (ir16 !== 1'b1 || ov16 !== 1'b0) begin n_fail++; $display("FAIL bp release: got ready=%b valid=%b want 1 0", ir16, ov16); end
    n_checks++; if (bcd16 !== e[19:0]) begin n_fail++; $display("FAIL bp bcd kept: got %h want %h", bcd16, e[19:0]); end
    iv16 = 0;
    @(posedge clk); #1;
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL bp no accept on handshake edge: busy got %b want 0", busy16); end
  endtask

  task automatic test_signed;
    logic [15:0] vals [5];
    logic [19:0] d; logic n; int lat; logic [39:0] e; logic en;
    vals[0] = 16'hFFFF; vals[1] = 16'h8000; vals[2] = 16'h0000; vals[3] = 16'h7FFF; vals[4] = 16'hFF85;
    for (int i = 0; i < 5; i++) begin
      conv16(vals[i], 1'b1, d, n, lat);
      model(16, {16'd0, vals[i]}, 1'b1, e, en);
      n_checks++; if (d !== e[19:0] || n !== en) begin n_fail++; $display("FAIL signed %h: got %h neg=%b want %h neg=%b", vals[i], d, n, e[19:0], en); end
    end
  endtask

  task automatic test_random;
    logic [15:0] v; logic sm;
    logic [19:0] d; logic n; int lat; logic [39:0] e; logic en;
    for (int i = 0; i < 24; i++) begin
      v = 16'($urandom); sm = 1'($urandom);
      conv16(v, sm, d, n, lat);
      model(16, {16'd0, v}, sm, e, en);
      n_checks++; if (d !== e[19:0] || n !== en || lat !== 16) begin
        n_fail++; $display("FAIL random %h sm=%b: got %h neg=%b lat=%0d want %h neg=%b lat=16", v, sm, d, n, lat, e[19:0], en); end
    end
  endtask

  task automatic test_reset_mid_conv;
    logic [19:0] d; logic n; int lat;
    bin16 = 16'd9999; signed_mode = 0; iv16 = 1;
    @(posedge clk); #1;
    iv16 = 0;
    repeat (5) @(posedge clk); #1;
    rst = 1;
    #1;
    n_checks++; if (ov16 !== 1'b0 || busy16 !== 1'b0 || ir16 !== 1'b1) begin
      n_fail++; $display("FAIL midreset flags: got valid=%b busy=%b ready=%b want 0 0 1", ov16, busy16, ir16); end
    n_checks++; if (bcd16 !== 20'h0 || neg16 !== 1'b0) begin n_fail++; $display("FAIL midreset data: got %h neg=%b want 00000 neg=0", bcd16, neg16); end
    @(posedge clk); #1;
    rst = 0;
    conv16(16'd42, 1'b0, d, n, lat);
    n_checks++; if (d !== 20'h00042 || n !== 1'b0) begin n_fail++; $display("FAIL midreset next: got %h neg=%b want 00042 neg=0", d, n); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] vals [3];
    int acc[$];
    int q = 0, r = 0, t = 0, d1, d2;
    logic [39:0] e; logic en;
    vals[0] = 16'd0; vals[1] = 16'd9999; vals[2] = 16'hFFFF;
    out_ready = 1; signed_mode = 0; bin16 = vals[0]; iv16 = 1;
    while (r < 3 && t < 200) begin
      if (ir16 && iv16) acc.push_back(t);
      if (ov16) begin
        model(16, {16'd0, vals[r]}, 1'b0, e, en);
        n_checks++; if (bcd16 !== e[19:0]) begin n_fail++; $display("FAIL b2b result %0d: got %h want %h", r, bcd16, e[19:0]); end
        r++;
      end
      @(posedge clk); #1;
      t++;
      if (acc.size() > q) begin
        q++;
        if (q < 3) bin16 = vals[q];
        else iv16 = 0;
      end
    end
    iv16 = 0; out_ready = 0;
    n_checks++; if (r !== 3 || acc.size() !== 3) begin n_fail++; $display("FAIL b2b count: got results=%0d accepts=%0d want 3 3", r, acc.size()); end
    d1 = acc.size() == 3 ? acc[1] - acc[0] : -1;
    d2 = acc.size() == 3 ? acc[2] - acc[1] : -1;
    n_checks++; if (d1 !== 18 || d2 !== 18) begin n_fail++; $display("FAIL b2b spacing: got %0d %0d want 18 18", d1, d2); end
  endtask

  task automatic test_width_sweep;
    int t1, t32;
    logic [39:0] e; logic en;
    for (int i = 0; i < 4; i++) begin
      bin1 = 1'(i); signed_mode = i[1];
      bin32 = i == 0 ? 32'hFFFFFFFF : $urandom;
      out_ready = 0; iv1 = 1; iv32 = 1;
      @(posedge clk); #1;
      iv1 = 0; iv32 = 0;
      t1 = -1; t32 = -1;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (ov1 && t1 < 0) t1 = k;
        if (ov32 && t32 < 0) t32 = k;
      end
      n_checks++; if (t1 !== 1 || t32 !== 32) begin n_fail++; $display("FAIL sweep latency: got w1=%0d w32=%0d want 1 32", t1, t32); end
      model(1, {31'd0, bin1}, signed_mode, e, en);
      n_checks++; if (bcd1 !== e[3:0] || neg1 !== en) begin
        n_fail++; $display("FAIL sweep w1 bin=%b sm=%b: got %h neg=%b want %h neg=%b", bin1, signed_mode, bcd1, neg1, e[3:0], en); end
      model(32, bin32, signed_mode, e, en);
      n_checks++; if (bcd32 !== e || neg32 !== en) begin
        n_fail++; $display("FAIL sweep w32 bin=%h sm=%b: got %h neg=%b want %h neg=%b", bin32, signed_mode, bcd32, neg32, e, en); end
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      n_checks++; if (ir1 !== 1'b1 || ir32 !== 1'b1) begin n_fail++; $display("FAIL sweep release: got %b %b want 1 1", ir1, ir32); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_unsigned_max;
    test_backpressure;
    test_signed;
    test_random;
    test_reset_mid_conv;
    test_back_to_back;
    test_width_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/double_dabble_bin2bcd_seq.md
# double_dabble_bin2bcd_seq

Sequential binary-to-BCD converter using the double-dabble algorithm, with valid/ready handshakes on input and output so it can sit directly in a streaming datapath, for example between the radix-4 Booth multiplier result and a display or UART formatter. It processes one bit per cycle with all BCD digits corrected in parallel. It is parametrised in width and digit count, and optionally supports two's-complement input with a sign output.

## Interface

**Parameters**
- `WIDTH`, default 16: binary input width, must be ≥ 1.
- `NUM_DIGITS`, default `get_num_digits(2**WIDTH - 1)`: number of BCD digits. This is 5 for the default width and at least 1.
- `CHECK_PARAM`, default 1: when set, simulation-only checks fire `$fatal` if `WIDTH < 1` or if `NUM_DIGITS` is too small for `2**WIDTH - 1`.

**Ports**
- `clk` in, 1: the single clock. All logic is rising-edge.
- `rst` in, 1: asynchronous, active-high reset.
- `in_valid` in, 1: `bin` and `signed_mode` are valid.
- `in_ready` out, 1: block can accept an input. High only in IDLE.
- `bin` in, `WIDTH`: binary operand.
- `signed_mode` in, 1: treat `bin` as two's complement. Sampled with `bin`.
- `out_valid` out, 1: `bcd`/`neg` hold a finished result.
- `out_ready` in, 1: downstream accepts the result.
- `bcd` out, `4*NUM_DIGITS`: packed digits. Digit i is in `bcd[4*i+3:4*i]`, and digit 0 is the least significant.
- `neg` out, 1: result is negative. The magnitude is in `bcd`.
- `busy` out, 1: high in CONV or HOLD.

## Operation

**FSM states:** IDLE, CONV, HOLD.

**IDLE**
- `in_ready` = 1.
- On an edge where `in_valid & in_ready`, capture into the shift register:
  - `mag` = `bin`, or `-bin` when the signed feature is active and `bin[WIDTH-1]` = 1.
  - `neg` is set accordingly.
- The same edge clears the BCD register, clears the bit counter and moves to CONV.

**CONV**, each cycle:
- Every digit ≥ 5 gets +3.
- Then the concatenation {BCD, `mag`} shifts left by 1.
- The counter increments. After the `WIDTH`th shift, go to HOLD.

**HOLD**
- `out_valid` = 1.
- `bcd` and `neg` are held stable until an edge with `out_ready` = 1, then go to IDLE.

**General rules**
- Magnitude arithmetic is `WIDTH` bits unsigned. The most negative input, `-2^(WIDTH-1)`, yields magnitude `2^(WIDTH-1)` without overflow.
- Zero gives `neg` = 0, including for signed zero.
- Inputs are ignored outside IDLE. `in_valid` in CONV/HOLD does not stall or corrupt a conversion.
- The output register is not updated until the next conversion starts. `bcd` keeps its value after the HOLD→IDLE handshake until the next input is accepted.

## Timing

- **Reset:** while `rst` is high, and immediately on assertion:
  - state = IDLE; `out_valid` = 0; `bcd` = 0; `neg` = 0; `busy` = 0; counter = 0.
  - `in_ready` reads 1, but no transfer occurs while `rst` is high.
- **Reset mid-CONV or mid-HOLD:** the conversion is aborted with no output, and the block returns to the reset state.
- **Latency:** input accepted at edge E0. `out_valid` is high from edge E0+`WIDTH`.
- **Throughput:** one conversion every `WIDTH`+2 edges with `out_ready` tied high (accept, `WIDTH` shifts, output handshake, IDLE accept).
- **Out-handshake edge:** `in_valid` is not accepted on the same edge as the output handshake. Acceptance resumes on the following edge.
- **Registered outputs:** `in_ready`, `out_valid` and `busy` decode from registered state only. There is no combinational path from `in_valid`/`out_ready` to any output.

## Configuration

Macro: `DOUBLE_DABBLE_SIGNED_EN`.

- **Defined:** `signed_mode` = 1 enables two's-complement interpretation and `neg` reports the sign.
- **Undefined:**
  - `signed_mode` is ignored and `bin` is always unsigned.
  - `neg` is constant 0.
  - The negation logic is not synthesised.
- Ports are identical in both builds.

## Test plan

- **Unsigned maximum:** reset, `WIDTH`=16, `bin`=16'hFFFF, `signed_mode`=0.
  - `out_valid` rises exactly 16 cycles after acceptance.
  - Digits 4..0 = 6,5,5,3,5; `neg`=0.
- **Backpressure:** `bin`=12345, `out_ready` low for 10 cycles after `out_valid`.
  - `bcd` = 1,2,3,4,5 is stable throughout.
  - `in_ready`=0 and `busy`=1 throughout.
  - Handshake on the 11th edge, then `in_ready`=1.
- **Signed:** `bin`=16'hFFFF with `signed_mode`=1.
  - With the macro: `bcd`=00001, `neg`=1.
  - Without the macro: `bcd`=65535, `neg`=0.
  - With the macro, `bin`=16'h8000 gives 32768 with `neg`=1.
- **Reset mid-CONV:** assert `rst` 5 cycles into the conversion of 9999.
  - All outputs go to reset values immediately.
  - The next input, 42, converts correctly to 00042.
- **Back-to-back with `out_ready`=1:**
  - Inputs 0, 9999 and 65535 give results 00000, 09999 and 65535.
  - Acceptances are spaced exactly 18 edges apart.
  - `in_valid` held during CONV has no effect.
- **Width sweep:** `WIDTH`=1 (`NUM_DIGITS`=1) and `WIDTH`=32 (`NUM_DIGITS`=10).
  - Exhaustive check for `WIDTH`=1.
  - `bin`=32'hFFFFFFFF gives 4294967295.
